// File: rtl/lsu_ctrl.sv
// Load/store initiator: one command at a time, single request/ack memory
// transaction, load writeback to the register file. Define LSU_TIMEOUT_EN for the ack timeout.
module lsu_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int RSEL_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [RSEL_W-1:0] cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic [RSEL_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [RSEL_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // cmd: transfer when cmd_valid && cmd_ready; cmd_* must be stable while cmd_valid is high.
  // mem: mem_req and its payload stay stable until the cycle mem_ack pulses.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              op_q;
  logic [RSEL_W-1:0] reg_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              ack_in_req;
  logic              timeout_hit;

  assign accept     = (state == IDLE) && cmd_valid;
  assign ack_in_req = (state == REQ) && mem_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Ack on the final allowed cycle wins over the timeout.
  assign timeout_hit = (state == REQ) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (accept)
        cnt_q <= '0;
      else if ((state == REQ) && !mem_ack)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = REQ;
      REQ: begin
        if (mem_ack)
          state_nxt = op_q ? IDLE : WB;
        else if (timeout_hit)
          state_nxt = IDLE;
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_req   = (state == REQ);
    rf_we     = (state == WB);
  end

  // One data register serves both directions: store data at accept, load data at ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 1'b0;
      reg_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      reg_q  <= cmd_reg;
      addr_q <= cmd_addr;
      if (cmd_op)
        data_q <= rf_rdata;
    end else if (ack_in_req && !op_q) begin
      data_q <= mem_rdata;
    end
  end

  assign rf_raddr  = cmd_reg;
  assign mem_we    = op_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign rf_waddr  = reg_q;
  assign rf_wdata  = data_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: vector table plus hand sequences, with a negedge monitor
// scoring memory requests and register writebacks against expected queues.
module tb_lsu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [1:0] cmd_reg;
  logic [7:0] cmd_addr;
  logic [1:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       busy;
  logic       err;
  logic [1:0] dbg_state;

  logic [7:0] rf_mem [4];
  assign rf_rdata = rf_mem[rf_raddr];

  lsu_ctrl #(.DATA_W(8), .ADDR_W(8), .RSEL_W(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: {we, addr, wdata} per request, request length, {waddr, wdata} per writeback.
  logic [16:0] mem_q[$];
  logic [7:0]  len_q[$];
  logic [9:0]  rf_q[$];
  logic        err_exp = 1'b0;

  typedef struct {
    logic        op;
    logic [1:0]  rsel;
    logic [7:0]  addr;
    logic [7:0]  rf_val;
    logic [7:0]  mem_val;
    int          waits;
    logic [16:0] exp_mem;
    logic [9:0]  exp_rf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic        prev_req = 1'b0;
  logic [16:0] hold;
  logic [16:0] e_mem;
  logic [9:0]  e_rf;
  logic [7:0]  req_len = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req) begin
        if (!prev_req) begin
          if (mem_q.size() == 0) begin
            check("mem_unexpected", 32'(mem_req), 32'd0);
          end else begin
            e_mem = mem_q.pop_front();
            check("mem_we", 32'(mem_we), 32'(e_mem[16]));
            check("mem_addr", 32'(mem_addr), 32'(e_mem[15:8]));
            if (e_mem[16]) check("mem_wdata", 32'(mem_wdata), 32'(e_mem[7:0]));
          end
          hold    = {mem_we, mem_addr, mem_wdata};
          req_len = 8'd1;
        end else begin
          check("mem_stable", 32'({mem_we, mem_addr, mem_wdata}), 32'(hold));
          req_len = req_len + 8'd1;
        end
      end else if (prev_req) begin
        if (len_q.size() == 0) check("len_unexpected", 32'(req_len), 32'd0);
        else check("req_len", 32'(req_len), 32'(len_q.pop_front()));
      end
      if (rf_we) begin
        if (rf_q.size() == 0) begin
          check("rf_unexpected", 32'(rf_we), 32'd0);
        end else begin
          e_rf = rf_q.pop_front();
          check("rf_waddr", 32'(rf_waddr), 32'(e_rf[9:8]));
          check("rf_wdata", 32'(rf_wdata), 32'(e_rf[7:0]));
        end
        check("wb_timing", 32'({prev_req, mem_req}), 32'b10);
      end
      check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      check("err", 32'(err), 32'(err_exp));
      prev_req = mem_req;
    end
  end

  // Drives one command and answers it after v.waits wait cycles; caller is at a negedge.
  task automatic run_vec(input vec_t v);
    mem_q.push_back(v.exp_mem);
    len_q.push_back(8'(v.waits + 1));
    if (!v.op) rf_q.push_back(v.exp_rf);
    rf_mem[v.rsel] = v.rf_val;
    cmd_op    = v.op;
    cmd_reg   = v.rsel;
    cmd_addr  = v.addr;
    cmd_valid = 1'b1;
    mem_rdata = ~v.mem_val;
    #1 check("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = ~v.op;
    cmd_addr  = ~v.addr;
    rf_mem[v.rsel] = ~v.rf_val;
    for (int i = 0; i <= v.waits; i++) begin
      if (i == v.waits) begin
        mem_ack   = 1'b1;
        mem_rdata = v.mem_val;
      end
      @(negedge clk);
      check("req_phase", 32'({mem_req, busy, cmd_ready}), 32'b110);
      @(posedge clk); #1;
    end
    mem_ack   = 1'b0;
    mem_rdata = ~v.mem_val;
    @(negedge clk);
    if (v.op) begin
      check("store_done", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);
    end else begin
      check("load_wb", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b1001);
      @(negedge clk);
      check("load_done", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);
    end
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    vec_t rv;
    vecs[0] = '{op:1'b0, rsel:2'd2, addr:8'h10, rf_val:8'h00, mem_val:8'hA5, waits:0,
                exp_mem:{1'b0, 8'h10, 8'h00}, exp_rf:{2'd2, 8'hA5}};
    vecs[1] = '{op:1'b1, rsel:2'd1, addr:8'hFF, rf_val:8'h3C, mem_val:8'h00, waits:3,
                exp_mem:{1'b1, 8'hFF, 8'h3C}, exp_rf:10'h0};
    vecs[2] = '{op:1'b0, rsel:2'd0, addr:8'h00, rf_val:8'h00, mem_val:8'hFF, waits:1,
                exp_mem:{1'b0, 8'h00, 8'h00}, exp_rf:{2'd0, 8'hFF}};
    vecs[3] = '{op:1'b1, rsel:2'd3, addr:8'h80, rf_val:8'h00, mem_val:8'h00, waits:0,
                exp_mem:{1'b1, 8'h80, 8'h00}, exp_rf:10'h0};
    vecs[4] = '{op:1'b0, rsel:2'd3, addr:8'h7F, rf_val:8'h00, mem_val:8'h5A, waits:2,
                exp_mem:{1'b0, 8'h7F, 8'h00}, exp_rf:{2'd3, 8'h5A}};
    vecs[5] = '{op:1'b1, rsel:2'd2, addr:8'h01, rf_val:8'hA5, mem_val:8'h00, waits:5,
                exp_mem:{1'b1, 8'h01, 8'hA5}, exp_rf:10'h0};
    vecs[6] = '{op:1'b0, rsel:2'd1, addr:8'hFE, rf_val:8'h00, mem_val:8'h00, waits:0,
                exp_mem:{1'b0, 8'hFE, 8'h00}, exp_rf:{2'd1, 8'h00}};

    for (int i = 0; i < 4; i++) rf_mem[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_reg = 2'd0; cmd_addr = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_outputs", 32'({mem_req, mem_we, mem_addr, mem_wdata, rf_we, rf_waddr, rf_wdata}), 32'd0);
    check("rst_status", 32'({busy, err, dbg_state}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'({cmd_ready, busy}), 32'b10);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int i = 0; i < 8; i++) begin
      rv.op      = 1'($urandom_range(0, 1));
      rv.rsel    = 2'($urandom_range(0, 3));
      rv.addr    = 8'($urandom_range(0, 255));
      rv.rf_val  = 8'($urandom_range(0, 255));
      rv.mem_val = 8'($urandom_range(0, 255));
      rv.waits   = $urandom_range(0, 4);
      rv.exp_mem = {rv.op, rv.addr, rv.op ? rv.rf_val : 8'h00};
      rv.exp_rf  = {rv.rsel, rv.mem_val};
      run_vec(rv);
    end

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 8'h42;
    @(negedge clk);
    check("stray_ack", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);
    mem_ack = 1'b0;
    @(negedge clk);
    check("stray_after", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);

    // Back-to-back with cmd_valid held high: store then load
    rf_mem[1] = 8'h11;
    mem_q.push_back({1'b1, 8'h20, 8'h11}); len_q.push_back(8'd1);
    mem_q.push_back({1'b0, 8'h30, 8'h00}); len_q.push_back(8'd2);
    rf_q.push_back({2'd3, 8'h77});
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_reg = 2'd1; cmd_addr = 8'h20;
    @(posedge clk); #1;
    cmd_op = 1'b0; cmd_reg = 2'd3; cmd_addr = 8'h30; mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    check("b2b_store_req", 32'({mem_req, cmd_ready}), 32'b10);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("b2b_idle", 32'({busy, cmd_ready, mem_req}), 32'b010);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_load_req1", 32'({mem_req, cmd_ready}), 32'b10);
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    @(negedge clk);
    check("b2b_load_req2", 32'({mem_req, cmd_ready}), 32'b10);
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 8'hEE;
    @(negedge clk);
    check("b2b_wb", 32'({rf_we, cmd_ready, busy}), 32'b101);
    @(negedge clk);
    check("b2b_end", 32'({busy, cmd_ready}), 32'b01);

    // Reset during REQ of a load
    mem_q.push_back({1'b0, 8'h44, 8'h00});
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 2'd2; cmd_addr = 8'h44;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_req", 32'(mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("abort_async", 32'({mem_req, busy, rf_we}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h99;
    @(negedge clk);
    check("abort_after", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);
    mem_ack = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'({busy, cmd_ready, mem_req, rf_we}), 32'b0100);

`ifdef LSU_TIMEOUT_EN
    // No ack: 15 request cycles, then a one-cycle err with no writeback
    mem_q.push_back({1'b0, 8'h55, 8'h00}); len_q.push_back(8'd15);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_reg = 2'd1; cmd_addr = 8'h55;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("to_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
    end
    err_exp = 1'b1;
    @(negedge clk);
    check("to_drop", 32'({mem_req, rf_we, busy}), 32'd0);
    @(posedge clk); #1;
    err_exp = 1'b0;
    @(negedge clk);
    check("to_idle", 32'({busy, cmd_ready}), 32'b01);
    // Ack on the 15th request cycle completes normally
    rv = '{op:1'b0, rsel:2'd2, addr:8'h66, rf_val:8'h00, mem_val:8'hC3, waits:14,
           exp_mem:{1'b0, 8'h66, 8'h00}, exp_rf:{2'd2, 8'hC3}};
    run_vec(rv);
`endif

    @(negedge clk);
    check("sb_drain", 32'(mem_q.size() + len_q.size() + rf_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
